// File: rtl/scalu_pipe.sv
// scalu_pipe: pipelined scalar ALU between exers and wb, 1..4 stages.
// Define SCALU_OVF_TRAP_EN to flag signed ADD/SUB overflow (ecause 12).
module scalu_pipe #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 1,
    parameter int ROBID_W = 7,
    parameter int RD_W    = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               exers_scalu_issue,
    input  logic [4:0]         exers_scalu_op,
    input  logic [ROBID_W-1:0] exers_robid,
    input  logic [RD_W-1:0]    exers_rd,
    input  logic [XLEN-1:0]    exers_op1,
    input  logic [XLEN-1:0]    exers_op2,
    output logic               scalu_stall,
    output logic               scalu_valid,
    output logic               scalu_error,
    output logic [4:0]         scalu_ecause,
    output logic [ROBID_W-1:0] scalu_robid,
    output logic [RD_W-1:0]    scalu_rd,
    output logic [XLEN-1:0]    scalu_result,
    input  logic               wb_scalu_stall,
    input  logic               rob_flush
);
    localparam int SHW  = $clog2(XLEN);
    localparam int LAST = DEPTH - 1;

    logic [DEPTH-1:0]   vld_q;
    logic [DEPTH-1:0]   vld_d;
    logic [DEPTH-1:0]   adv;
    logic               accept;

    logic [4:0]         op_q;
    logic [ROBID_W-1:0] robid0_q;
    logic [RD_W-1:0]    rd0_q;
    logic [XLEN-1:0]    op1_q;
    logic [XLEN-1:0]    op2_q;

    logic [XLEN-1:0]    sum;
    logic               lt_s;
    logic               lt_u;
    logic [SHW-1:0]     shamt;
    logic [XLEN-1:0]    alu_res;
    logic               alu_err;
    logic               last_err;

    // A stage is blocked only if every later stage is full and wb stalls
    always_comb begin
        logic blk;
        adv = '0;
        for (int i = 0; i < DEPTH; i++) begin
            blk = wb_scalu_stall;
            for (int j = i + 1; j < DEPTH; j++) begin
                blk = blk & vld_q[j];
            end
            adv[i] = vld_q[i] & ~blk;
        end
    end

    assign scalu_stall = vld_q[0] & ~adv[0];
    assign accept      = exers_scalu_issue & ~scalu_stall;

    // Next valid per stage: filled from upstream or held while blocked
    always_comb begin
        vld_d    = '0;
        vld_d[0] = accept | (vld_q[0] & ~adv[0]);
        for (int i = 1; i < DEPTH; i++) begin
            vld_d[i] = adv[i-1] | (vld_q[i] & ~adv[i]);
        end
    end

    // Valid bits; flush and reset win over any advance
    always_ff @(posedge clk) begin
        if (rst || rob_flush) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // Stage 0 operand capture on an accepted issue
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q     <= exers_scalu_op;
            robid0_q <= exers_robid;
            rd0_q    <= exers_rd;
            op1_q    <= exers_op1;
            op2_q    <= exers_op2;
        end
    end

    assign sum   = op_q[3] ? (op1_q - op2_q) : (op1_q + op2_q);
    assign lt_s  = $signed(op1_q) < $signed(op2_q);
    assign lt_u  = op1_q < op2_q;
    assign shamt = op2_q[SHW-1:0];

    // Operation decode; op[4] selects the min/max group
    always_comb begin
        alu_res = '0;
        if (op_q[4]) begin
            case (op_q[2:0])
                3'b000:  alu_res = lt_s ? op1_q : op2_q;
                3'b001:  alu_res = lt_s ? op2_q : op1_q;
                3'b010:  alu_res = lt_u ? op1_q : op2_q;
                3'b011:  alu_res = lt_u ? op2_q : op1_q;
                default: alu_res = '0;
            endcase
        end else begin
            unique case (op_q[2:0])
                3'b000: alu_res = sum;
                3'b001: alu_res = op1_q << shamt;
                3'b010: alu_res = {{(XLEN-1){1'b0}}, lt_s};
                3'b011: alu_res = {{(XLEN-1){1'b0}}, lt_u};
                3'b100: alu_res = op_q[3]
                                ? {{(XLEN-1){1'b0}}, op1_q == op2_q}
                                : op1_q ^ op2_q;
                3'b101: alu_res = op_q[3]
                                ? op1_q >> shamt
                                : $unsigned($signed(op1_q) >>> shamt);
                3'b110: alu_res = op1_q | op2_q;
                3'b111: alu_res = op1_q & op2_q;
            endcase
        end
    end

`ifdef SCALU_OVF_TRAP_EN
    // ADD needs equal operand signs, SUB differing ones, then a sign flip
    assign alu_err = ~op_q[4] & (op_q[2:0] == 3'b000)
                   & ((op1_q[XLEN-1] ^ op2_q[XLEN-1]) == op_q[3])
                   & (sum[XLEN-1] != op1_q[XLEN-1]);
`else
    assign alu_err = 1'b0;
`endif

    generate
        if (DEPTH == 1) begin : g_d1
            assign scalu_result = alu_res;
            assign scalu_robid  = robid0_q;
            assign scalu_rd     = rd0_q;
            assign last_err     = alu_err;
        end else begin : g_dn
            logic [XLEN-1:0]    res_q   [1:LAST];
            logic [ROBID_W-1:0] robid_q [1:LAST];
            logic [RD_W-1:0]    rd_q    [1:LAST];
            logic               err_q   [1:LAST];

            // Stage 1 registers the result; later stages shift it along
            always_ff @(posedge clk) begin
                if (adv[0]) begin
                    res_q[1]   <= alu_res;
                    robid_q[1] <= robid0_q;
                    rd_q[1]    <= rd0_q;
                    err_q[1]   <= alu_err;
                end
                for (int i = 2; i <= LAST; i++) begin
                    if (adv[i-1]) begin
                        res_q[i]   <= res_q[i-1];
                        robid_q[i] <= robid_q[i-1];
                        rd_q[i]    <= rd_q[i-1];
                        err_q[i]   <= err_q[i-1];
                    end
                end
            end

            assign scalu_result = res_q[LAST];
            assign scalu_robid  = robid_q[LAST];
            assign scalu_rd     = rd_q[LAST];
            assign last_err     = err_q[LAST];
        end
    endgenerate

    assign scalu_valid  = vld_q[LAST];
    assign scalu_error  = vld_q[LAST] & last_err;
    assign scalu_ecause = scalu_error ? 5'd12 : 5'd0;

endmodule
